pc_fetch: RTL

Instruction-fetch front end of the MIPS core. Owns the program-counter register and issues word-addressed fetch requests to instruction memory. Buffers returned instructions with their PC toward decode, and accepts redirects from next-PC selection (branch/jump target) and stalls via decode backpressure. It supplies the current PC that next-PC selection consumes and loads the next PC that it produces.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 46 ++++
 rtl/pc_fetch.sv | 88 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and build-time parameters for the instruction-fetch front end.
// FETCH_SKID_EN selects a two-entry skid buffer; otherwise one entry.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

`ifdef FETCH_SKID_EN
  localparam int FETCH_DEPTH = 2;
`else
  localparam int FETCH_DEPTH = 1;
`endif

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  function automatic int fetch_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small shift-register FIFO of fetched {pc, instr}; head is always slot 0 so the
// decode-facing outputs come straight from registers.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int CW    = fetch_cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  fetch_entry_t  push_data,
  output fetch_entry_t  head,
  output logic          head_valid,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [CW-1:0] wr_idx;

  // With a simultaneous pop the new entry lands one slot lower.
  assign wr_idx = count - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (pop) mem[i] <= mem[i+1];
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (push && wr_idx == CW'(i)) mem[i] <= push_data;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head       = mem[0];
  assign head_valid = (count != '0);

endmodule

// File: rtl/pc_fetch.sv
// Fetch front end: PC register, credit-based request issue, stale-response
// tracking and the decode-facing buffer. Buffer depth follows FETCH_SKID_EN.
module pc_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int CW = fetch_cnt_w(FETCH_DEPTH);

  logic [31:0]  pc_q;
  logic [31:0]  inflight_addr_q;
  logic         inflight_q;
  logic         stale_q;
  logic         run_q;
  logic         accept;
  logic         pop;
  logic         push;
  logic [CW:0]  credit_used;
  logic [CW-1:0] count;
  fetch_entry_t head;
  fetch_entry_t rsp_entry;

  assign pop         = if_valid & if_ready;
  assign credit_used = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);

  // run_q holds requests off until the first edge after reset release.
  assign imem_req_valid = run_q & ~redirect_valid & (credit_used < (CW+1)'(FETCH_DEPTH));
  assign accept         = imem_req_valid & imem_req_ready;
  assign imem_req_addr  = pc_q;

  assign push = imem_rsp_valid & inflight_q & ~stale_q & ~redirect_valid;

  always_comb begin
    rsp_entry       = '0;
    rsp_entry.pc    = inflight_addr_q;
    rsp_entry.instr = imem_rsp_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q           <= 1'b0;
      pc_q            <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      stale_q         <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= accept;
      if (accept) inflight_addr_q <= pc_q;
      // A redirect poisons anything issued before it until a fresh request goes out.
      if (redirect_valid)  stale_q <= 1'b1;
      else if (accept)     stale_q <= 1'b0;
      if (redirect_valid)  pc_q <= redirect_pc;
      else if (accept)     pc_q <= pc_q + 32'd1;
    end
  end

  fetch_fifo #(.DEPTH(FETCH_DEPTH), .CW(CW)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (push),
    .pop        (pop),
    .push_data  (rsp_entry),
    .head       (head),
    .head_valid (if_valid),
    .count      (count)
  );

  assign if_instr = head.instr;
  assign if_pc    = head.pc;

endmodule
